// File: rtl/piso_serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, LSB-first data, stop bit, each CLKS_PER_BIT clocks.
// Define TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module piso_serial_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic [WIDTH-1:0] DIN,
   input  logic             LOAD,
   output logic             READY,
   output logic             BUSY,
   output logic             SOUT,
   output logic             DONE
);
   // state    | meaning
   // S_IDLE   | line high, ready for a word
   // S_START  | start bit (low)
   // S_DATA   | data bits, LSB first, from shift register bit 0
   // S_PARITY | even parity of the latched word (TX_PARITY_EN only)
   // S_STOP   | stop bit (high); DONE pulses on exit

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(WIDTH + 1);

`ifdef TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic             done_q, done_d;
   logic             bit_end;
`ifdef TX_PARITY_EN
   logic             par_q, par_d;
`endif

   assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sr_q    <= '0;
         done_q  <= 1'b0;
`ifdef TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sr_q    <= sr_d;
         done_q  <= done_d;
`ifdef TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sr_d    = sr_q;
      done_d  = 1'b0;
`ifdef TX_PARITY_EN
      par_d   = par_q;
`endif
      // Cycle counter runs continuously inside a frame, wrapping at every bit boundary.
      if (state_q != S_IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end
      case (state_q)
         S_IDLE: begin
            if (LOAD) begin
               state_d = S_START;
               sr_d    = DIN;
               cnt_d   = '0;
               bit_d   = '0;
`ifdef TX_PARITY_EN
               par_d   = ^DIN;
`endif
            end
         end
         S_START: begin
            if (bit_end) state_d = S_DATA;
         end
         S_DATA: begin
            if (bit_end) begin
               sr_d = sr_q >> 1;
               if (bit_q == BW'(WIDTH - 1)) begin
                  bit_d = '0;
`ifdef TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
`ifdef TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      SOUT = 1'b1;
      case (state_q)
         S_START:  SOUT = 1'b0;
         S_DATA:   SOUT = sr_q[0];
`ifdef TX_PARITY_EN
         S_PARITY: SOUT = par_q;
`endif
         default:  SOUT = 1'b1;
      endcase
   end

   assign READY = (state_q == S_IDLE);
   assign BUSY  = ~READY;
   assign DONE  = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Self-checking bench for piso_serial_tx: two instances (4 and 1 clocks per bit), SOUT scoreboard per cycle.
module tb_piso_serial_tx;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         clr_n;
   logic [W-1:0] din4, din1;
   logic         load4, load1;
   logic         ready4, busy4, sout4, done4;
   logic         ready1, busy1, sout1, done1;

   logic exp_q[$];
   int   n_asserts = 0;
   int   n_fail    = 0;

   always #5 clk = ~clk;

   piso_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(4)) u_dut4 (
      .CLK(clk), .CLR(clr_n), .DIN(din4), .LOAD(load4),
      .READY(ready4), .BUSY(busy4), .SOUT(sout4), .DONE(done4)
   );

   piso_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(1)) u_dut1 (
      .CLK(clk), .CLR(clr_n), .DIN(din1), .LOAD(load1),
      .READY(ready1), .BUSY(busy1), .SOUT(sout1), .DONE(done1)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_line(input bit fast, input string tag,
                           input logic s, input logic r, input logic b, input logic d);
      chk({tag, "_sout"},  fast ? sout1  : sout4,  s);
      chk({tag, "_ready"}, fast ? ready1 : ready4, r);
      chk({tag, "_busy"},  fast ? busy1  : busy4,  b);
      chk({tag, "_done"},  fast ? done1  : done4,  d);
   endtask

   // Expected SOUT for every cycle of a frame, built from the data word alone.
   task automatic push_frame(input bit fast, input logic [W-1:0] data);
      int cpb;
      cpb = fast ? 1 : 4;
      for (int r = 0; r < cpb; r++) exp_q.push_back(1'b0);
      for (int i = 0; i < W; i++)
         for (int r = 0; r < cpb; r++) exp_q.push_back(data[i]);
`ifdef TX_PARITY_EN
      for (int r = 0; r < cpb; r++) exp_q.push_back(^data);
`endif
      for (int r = 0; r < cpb; r++) exp_q.push_back(1'b1);
   endtask

   task automatic accept(input bit fast, input logic [W-1:0] data, input bit keep);
      int guard;
      guard = 0;
      while ((fast ? ready1 : ready4) !== 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("accept_ready", fast ? ready1 : ready4, 1'b1);
      if (fast) begin
         din1  = data;
         load1 = 1'b1;
      end else begin
         din4  = data;
         load4 = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!keep) begin
         load1 = 1'b0;
         load4 = 1'b0;
      end
      push_frame(fast, data);
   endtask

   task automatic drain(input bit fast, input string tag);
      int n;
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk_line(fast, tag, exp_q.pop_front(), 1'b0, 1'b1, 1'b0);
      end
      @(negedge clk);
      chk_line(fast, {tag, "_end"}, 1'b1, 1'b1, 1'b0, 1'b1);
   endtask

   initial begin
      clr_n = 1'b0;
      load4 = 1'b0;
      load1 = 1'b0;
      din4  = '0;
      din1  = '0;
      repeat (3) @(negedge clk);
      chk_line(1'b0, "rst4", 1'b1, 1'b1, 1'b0, 1'b0);
      chk_line(1'b1, "rst1", 1'b1, 1'b1, 1'b0, 1'b0);
      clr_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk_line(1'b0, "idle4", 1'b1, 1'b1, 1'b0, 1'b0);
         chk_line(1'b1, "idle1", 1'b1, 1'b1, 1'b0, 1'b0);
      end

      accept(1'b0, 8'hA5, 1'b0);
      drain(1'b0, "xa5");

      @(negedge clk);
      accept(1'b0, 8'h07, 1'b0);
      drain(1'b0, "x07");

      // LOAD held through the frame with a new DIN; it must be ignored until READY returns.
      @(negedge clk);
      accept(1'b0, 8'h3C, 1'b1);
      din4 = 8'hFF;
      drain(1'b0, "x3c");
      @(posedge clk);
      #1;
      load4 = 1'b0;
      push_frame(1'b0, 8'hFF);
      drain(1'b0, "xff");

      // Reset mid-frame: the partial frame is dropped and nothing resumes.
      @(negedge clk);
      accept(1'b0, 8'h00, 1'b0);
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         chk_line(1'b0, "pre_clr", exp_q.pop_front(), 1'b0, 1'b1, 1'b0);
      end
      @(negedge clk);
      clr_n = 1'b0;
      #1;
      chk_line(1'b0, "clr_imm", 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk_line(1'b0, "clr_hold", 1'b1, 1'b1, 1'b0, 1'b0);
      end
      clr_n = 1'b1;
      exp_q.delete();
      repeat (30) begin
         @(negedge clk);
         chk_line(1'b0, "post_clr", 1'b1, 1'b1, 1'b0, 1'b0);
      end

      accept(1'b1, 8'h81, 1'b0);
      drain(1'b1, "x81");
      @(negedge clk);
      chk_line(1'b1, "x81_after", 1'b1, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/piso_serial_tx.md
Name: piso_serial_tx

Overview:
Parallel-in, serial-out frame transmitter. It is the sending end for the single-bit registered capture path used in our labs.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Shifts the word out on one line: start bit, then data LSB-first, then stop bit.
- Each bit is held for CLKS_PER_BIT clocks.
- Sits between a parallel data source and any serial link or bit-capture stage.

Parameters:
WIDTH, 8, data word width in bits (min 1)
CLKS_PER_BIT, 4, clocks each serial bit is held on SOUT (min 1)

Ports:
CLK  input  1  clock; all state changes on posedge
CLR  input  1  asynchronous, active-low reset
DIN  input  WIDTH  parallel word to send; sampled only at accept
LOAD  input  1  valid; word is accepted on a posedge where LOAD=1 and READY=1
READY  output  1  block can accept a word
BUSY  output  1  a frame is in progress
SOUT  output  1  serial line; idles high
DONE  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (CLR=0, asynchronous, at any time including mid-frame):
  - Outputs go immediately to SOUT=1, READY=1, BUSY=0, DONE=0.
  - State goes to IDLE; bit counter, cycle counter and shift register clear.
  - Any partial frame is discarded. Nothing resumes after CLR rises.
- States: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
- IDLE:
  - SOUT=1, READY=1, BUSY=0.
  - LOAD=1 at edge E0: latch DIN into the shift register, go to START. From E0: READY=0, BUSY=1.
- START:
  - SOUT=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - SOUT = shift register bit 0. Shift right after every CLKS_PER_BIT cycles.
  - Bit i is driven during cycles [E0+(1+i)*CLKS_PER_BIT, E0+(2+i)*CLKS_PER_BIT).
  - After WIDTH bits, go to STOP.
- STOP:
  - SOUT=1 for CLKS_PER_BIT cycles.
  - At edge Ef = E0+(WIDTH+2)*CLKS_PER_BIT: go to IDLE. For one cycle: READY=1, BUSY=0, DONE=1.
- Frame length is (WIDTH+2)*CLKS_PER_BIT cycles. There are no idle gaps inside a frame.
- Back-to-back frames: LOAD=1 at edge Ef+1 (first cycle READY is high again) is accepted. SOUT drops straight from stop-high to start-low, with no extra idle bit.
- LOAD while READY=0 is ignored, with no side effects. DIN changes after accept do not affect the frame in flight.
- Counters:
  - Cycle counter width is clog2(CLKS_PER_BIT), minimum 1 bit. It wraps to 0 at each bit boundary.
  - Bit counter width is clog2(WIDTH+1).
- CLKS_PER_BIT=1: each bit lasts one cycle, and the frame is WIDTH+2 cycles.
- DONE is never asserted except in the single cycle after Ef.

Optional Feature:
Macro TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - SOUT = XOR of the latched word (even parity) for CLKS_PER_BIT cycles.
  - Frame length is (WIDTH+3)*CLKS_PER_BIT cycles, and Ef shifts by CLKS_PER_BIT.
- Not defined: no PARITY state, and frame timing is exactly as in Behaviour.

Test Plan:
- Reset, then idle 10 cycles -> SOUT=1, READY=1, BUSY=0, DONE=0 throughout.
- WIDTH=8, CLKS_PER_BIT=4; LOAD=1 with DIN=8'hA5 for one cycle -> SOUT holds 0,1,0,1,0,0,1,0,1,1, each for 4 cycles. READY is low for exactly 40 cycles. DONE pulses once, 40 cycles after accept.
- Accept 8'h3C, then hold LOAD=1 with DIN=8'hFF throughout the frame -> first frame sends 3C bits unchanged. 8'hFF is accepted in the cycle READY returns. SOUT goes 1 to 0 with no extra idle period, then sends eight 1s.
- Accept 8'h00, assert CLR=0 at cycle 15 of the frame for 3 cycles -> SOUT=1 and READY=1 immediately while CLR=0. No DONE pulse. After CLR=1 the block stays idle until a new LOAD.
- CLKS_PER_BIT=1, DIN=8'h81 -> SOUT sequence 0,1,0,0,0,0,0,0,1,1 over 10 cycles; DONE at cycle 10.
- TX_PARITY_EN defined, CLKS_PER_BIT=4 -> for 8'hA5 the parity bit is 0; for 8'h07 the parity bit is 1. Frames are 44 cycles long and DONE pulses 44 cycles after accept.
